// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: 64-bit-wide data memory with byte-lane-masked stores and 1-cycle row loads.
// The array is zero-cleared row by row after reset before requests are accepted.
module data_mem_ctrl #(
    parameter int MEM_SIZE = 524288
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_mem_req_i,
    input  logic [63:0] data_mem_addr_i,
    input  logic        data_mem_wr_i,
    input  logic [63:0] data_mem_wr_data_i,
    input  logic [2:0]  data_mem_row_idx_i,
    input  logic [1:0]  data_byte_en_i,
    output logic        mem_ready_o,
    output logic [63:0] mem_rd_data_o,
    output logic        mem_rd_valid_o
);
    localparam int DEPTH = MEM_SIZE / 8;
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic {INIT, RUN} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [63:0]      rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic [63:0]      mem_q [DEPTH];

    logic             accept, we;
    logic [IDX_W-1:0] req_row, wr_row;
    logic [7:0]       size_mask, lane_en;
    logic [63:0]      wr_word;
    logic             unused_addr;

    // Row index comes from the aligned address; offset and high bits are not ours to decode.
    assign req_row     = data_mem_addr_i[IDX_W+2:3];
    assign unused_addr = ^{data_mem_addr_i[63:IDX_W+3], data_mem_addr_i[2:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= INIT;
            cnt_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == INIT) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_q == IDX_W'(DEPTH - 1)) ? RUN : INIT;
        end
    end

    always_comb begin
        mem_ready_o = (state_q == RUN);
        accept      = data_mem_req_i & mem_ready_o;
        size_mask   = (data_byte_en_i == 2'b00) ? 8'h01 :
                      (data_byte_en_i == 2'b01) ? 8'h03 :
                      (data_byte_en_i == 2'b10) ? 8'h0F : 8'hFF;
        // Lanes pushed beyond byte 7 fall off the 8-bit mask, so a misaligned store stays in its row.
        we          = (state_q == INIT) | (accept & data_mem_wr_i);
        wr_row      = (state_q == INIT) ? cnt_q : req_row;
        lane_en     = (state_q == INIT) ? 8'hFF : size_mask << data_mem_row_idx_i;
        wr_word     = (state_q == INIT) ? 64'h0 : data_mem_wr_data_i << {data_mem_row_idx_i, 3'b000};
        rd_valid_d  = accept & ~data_mem_wr_i;
        rd_data_d   = rd_valid_d ? mem_q[req_row] : rd_data_q;
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < 8; b++)
            if (we && lane_en[b]) mem_q[wr_row][8*b +: 8] <= wr_word[8*b +: 8];
    end

    assign mem_rd_data_o  = rd_data_q;
    assign mem_rd_valid_o = rd_valid_q;
endmodule
